// File: rtl/midi_pkg.sv
// Shared MIDI definitions: line rate, frame shape, serialiser state encoding and
// common status bytes used by benches and the transmit path.
package midi_pkg;

  localparam int unsigned MIDI_BAUD       = 31250;
  localparam int unsigned MIDI_FRAME_BITS = 10;
  localparam int unsigned MIDI_DATA_BITS  = 8;

  typedef logic [MIDI_DATA_BITS-1:0] midi_byte_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } midi_tx_state_e;

  localparam midi_byte_t MIDI_NOTE_OFF     = 8'h80;
  localparam midi_byte_t MIDI_NOTE_ON      = 8'h90;
  localparam midi_byte_t MIDI_CTRL_CHANGE  = 8'hB0;
  localparam midi_byte_t MIDI_PROG_CHANGE  = 8'hC0;

  // Clock cycles per bit, rounded to nearest.
  function automatic int unsigned midi_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/midi_uart_tx_if.sv
// Byte handshake between the MCU-side register logic and a MIDI transmitter.
interface midi_uart_tx_if;
  import midi_pkg::*;

  midi_byte_t tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, output tx_ready);

endinterface

// File: rtl/midi_tx_fifo.sv
// Small synchronous byte FIFO with occupancy output; reset flushes all entries.
module midi_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("midi_tx_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_en;
  logic             pop_en;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_en, pop_en})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/midi_uart_tx.sv
// MIDI transmitter: buffers bytes in a FIFO and serialises them 8N1, LSB first,
// onto a registered, idle-high line. Back-to-back frames run with no idle gap.
module midi_uart_tx
  import midi_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 12000000,
  parameter int unsigned BAUD       = MIDI_BAUD,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  midi_uart_tx_if.slave               tx,
  output logic                        midi_out,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int unsigned DIV    = midi_div(CLK_HZ, BAUD);
  localparam int unsigned BAUD_W = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV - 1);

  if (DIV < 2) begin : g_bad_div
    $error("midi_uart_tx: CLK_HZ/BAUD gives fewer than 2 clocks per bit");
  end

  midi_tx_state_e    state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  midi_byte_t        shift_q, shift_d;
  logic              out_q, out_d;
  logic              pop_c;
  logic              baud_end_c;
  logic              fifo_full;
  logic              fifo_empty;
  midi_byte_t        fifo_data;

  assign tx.tx_ready = !fifo_full;

  midi_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (MIDI_DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tx.tx_valid),
    .data_i  (tx.tx_data),
    .pop_i   (pop_c),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign baud_end_c = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          shift_d = fifo_data;
          baud_d  = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_end_c) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_end_c) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) state_d = ST_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_STOP: begin
        // Chain straight into the next start bit when another byte is waiting.
        if (baud_end_c) begin
          baud_d = '0;
          if (!fifo_empty) begin
            pop_c   = 1'b1;
            shift_d = fifo_data;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_d = 1'b1;
    case (state_q)
      ST_START: out_d = 1'b0;
      ST_DATA:  out_d = shift_q[0];
      default:  out_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      out_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      out_q   <= out_d;
    end
  end

  assign midi_out = out_q;
  assign busy     = (state_q != ST_IDLE) || (fifo_level != '0);

endmodule

// File: tb/tb_midi_uart_tx.sv
// Bench for midi_uart_tx: random byte traffic scored by a line-decoding monitor
// against a frame-timing reference model, plus reset, full-FIFO and default-rate checks.
`timescale 1ns/1ps
module tb_midi_uart_tx;
  import midi_pkg::*;

  localparam int unsigned SIM_CLK_HZ = 312500;
  localparam int          DIV        = 10;
  localparam int          FRAME      = 10 * DIV;
  localparam int          DEF_DIV    = 384;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  midi_uart_tx_if ifs ();
  midi_uart_tx_if ifd ();

  logic       midi_out, busy;
  logic [2:0] fifo_level;
  logic       midi_out_d, busy_d;
  logic [2:0] fifo_level_d;

  midi_uart_tx #(.CLK_HZ(SIM_CLK_HZ), .BAUD(MIDI_BAUD), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .tx(ifs), .midi_out(midi_out), .busy(busy), .fifo_level(fifo_level));

  midi_uart_tx dut_def (
    .clk(clk), .rst(rst), .tx(ifd), .midi_out(midi_out_d), .busy(busy_d), .fifo_level(fifo_level_d));

  typedef struct {
    logic [7:0] data;
    longint     start;
  } exp_t;

  exp_t   sb_q[$];
  longint last_start = -1000;
  longint cyc = 0;
  int     tests = 0;
  int     fails = 0;
  bit     mon_en = 1'b0;
  bit     full_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  // The model: a frame starts 2 edges after acceptance, but never before the previous frame ends.
  task automatic send(input logic [7:0] b);
    int     waited;
    longint acc, st;
    ifs.tx_valid = 1'b1;
    ifs.tx_data  = b;
    waited = 0;
    while (!ifs.tx_ready && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    if (!ifs.tx_ready) begin
      check("send_timeout", 0, 1);
      ifs.tx_valid = 1'b0;
      return;
    end
    acc = cyc + 1;
    st  = (acc + 2 > last_start + FRAME) ? acc + 2 : last_start + FRAME;
    sb_q.push_back('{data: b, start: st});
    last_start = st;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    ifs.tx_valid = 1'b0;
    n = 0;
    while ((sb_q.size() != 0 || busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", n < 2000, 1);
    repeat (5) @(negedge clk);
    check("idle_line", midi_out, 1);
    check("idle_level", fifo_level, 0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("tx_ready_vs_level", ifs.tx_ready, (fifo_level != 3'd4));
      if (fifo_level == 3'd4) full_seen = 1'b1;
    end
  end

  // Line decoder: samples each bit at its centre and scores against the model queue.
  initial begin
    longint     s;
    logic [7:0] b;
    exp_t       e;
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (midi_out == 1'b0) begin
        s = cyc;
        repeat (DIV / 2) @(negedge clk);
        check("start_bit", midi_out, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = midi_out;
        end
        repeat (DIV) @(negedge clk);
        check("stop_bit", midi_out, 1);
        if (sb_q.size() == 0) begin
          check("unexpected_frame", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("frame_data", b, e.data);
          check("frame_start", s, e.start);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 300000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    longint s, acc, tf, first_rise, last_rise;
    int     rises, lows, n;
    logic   prev, busy_mid, busy_end;

    rst = 1'b1;
    ifs.tx_valid = 1'b0; ifs.tx_data = '0;
    ifd.tx_valid = 1'b0; ifd.tx_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_line", midi_out, 1);
    check("rst_level", fifo_level, 0);
    check("rst_ready", ifs.tx_ready, 1);
    check("rst_busy", busy, 0);

    // Reset in the middle of bit 1 of 0x55 (a low bit) with another byte queued.
    send(8'h55);
    send(8'h3C);
    ifs.tx_valid = 1'b0;
    s = sb_q[0].start;
    while (cyc < s + 25) @(negedge clk);
    check("pre_rst_line", midi_out, 0);
    check("pre_rst_level", fifo_level, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_line", midi_out, 1);
    check("async_rst_level", fifo_level, 0);
    check("async_rst_ready", ifs.tx_ready, 1);
    check("async_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    lows = 0;
    repeat (30) begin
      @(negedge clk);
      if (!midi_out) lows++;
    end
    check("post_rst_low_samples", lows, 0);
    sb_q.delete();
    last_start = -1000;
    mon_en = 1'b1;

    // Single note-on status byte; busy holds through the stop bit.
    send(MIDI_NOTE_ON);
    ifs.tx_valid = 1'b0;
    s = last_start;
    while (cyc < s + 90) @(negedge clk);
    check("busy_in_stop", busy, 1);
    while (cyc < s + FRAME) @(negedge clk);
    check("busy_after_stop", busy, 0);
    drain();

    // Burst, then a push landing on the edge that pops the next byte.
    send(8'h90);
    send(8'h3C);
    send(8'h7F);
    ifs.tx_valid = 1'b0;
    check("burst_level", fifo_level, 2);
    s = sb_q[1].start;
    while (cyc < s - 2) @(negedge clk);
    check("pre_pushpop_level", fifo_level, 2);
    send(8'h45);
    ifs.tx_valid = 1'b0;
    check("pushpop_level", fifo_level, 2);
    drain();

    // Six bytes with valid held: FIFO fills, nothing is lost.
    full_seen = 1'b0;
    for (int i = 0; i < 6; i++) send(8'($urandom));
    drain();
    check("fifo_reached_full", full_seen, 1);

    // Randomised traffic with random gaps.
    for (int i = 0; i < 24; i++) begin
      send(8'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        ifs.tx_valid = 1'b0;
        repeat ($urandom_range(0, 150)) @(negedge clk);
      end
    end
    drain();
    check("scoreboard_empty", sb_q.size(), 0);

    // Default 12 MHz instance: bit period and frame length at full rate.
    @(negedge clk);
    ifd.tx_valid = 1'b1;
    ifd.tx_data  = 8'h55;
    @(posedge clk);
    @(negedge clk);
    ifd.tx_valid = 1'b0;
    acc = cyc;
    n = 0;
    while (midi_out_d && n < 10) begin
      @(negedge clk);
      n++;
    end
    tf = cyc;
    check("def_latency", tf, acc + 2);
    rises = 0; first_rise = 0; last_rise = 0;
    busy_mid = 1'b0; busy_end = 1'b1;
    prev = midi_out_d;
    while (cyc < tf + 10 * DEF_DIV + 5) begin
      @(negedge clk);
      if (!prev && midi_out_d) begin
        rises++;
        if (rises == 1) first_rise = cyc;
        last_rise = cyc;
      end
      if (cyc == tf + 10 * DEF_DIV - 10) busy_mid = busy_d;
      if (cyc == tf + 10 * DEF_DIV)      busy_end = busy_d;
      prev = midi_out_d;
    end
    check("def_bit_period", first_rise - tf, DEF_DIV);
    check("def_stop_start", last_rise - tf, 9 * DEF_DIV);
    check("def_rise_count", rises, 5);
    check("def_busy_in_stop", busy_mid, 1);
    check("def_busy_after_frame", busy_end, 0);
    check("def_line_idle", midi_out_d, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
